regfile_ext: RTL and testbench
==============================

# regfile_ext

Parametrised successor to the CPU's general-purpose register file. It provides two read ports and one debug read port. Its write port applies load-result extraction: byte or half-word selected by address offset, sign- or zero-extended. It adds write-to-read bypass, a per-register pending-load busy scoreboard, and a sequential clear engine that sweeps the array after reset or on request. It sits between the decode stage (reads, busy checks) and writeback (writes, memory-op selection).

## Interface
- XLEN, 32, data width in bits; must be ≥ 32 and a multiple of 8.
- NREG, 32, number of registers; power of two, ≥ 4.
- AW, $clog2(NREG), register address width (derived; not overridden).
- BYPASS, 1, 1 = same-cycle write data is forwarded to RD1/RD2; 0 = reads see array contents only.
- clk  in  1  clock. One clock; all state changes on the rising edge.
- rst  in  1  reset. Synchronous, active-high.
- clr  in  1  request a full array clear; honoured only when ready = 1.
- ready  out  1  1 when the clear engine is idle and the port accepts writes.
- we  in  1  write enable.
- A1, A2  in  AW  read addresses (rs, rt).
- A3  in  AW  write address (rd).
- WD  in  XLEN  raw writeback data.
- mem_op  in  2  00 word (ALU), 01 byte, 10 half, 11 word (load).
- lsign  in  1  1 = sign-extend byte/half; 0 = zero-extend.
- addr  in  2  low address bits selecting the byte or half.
- set_busy  in  1  mark register bsy_a as having a pending load.
- bsy_a  in  AW  scoreboard set address.
- RD1, RD2  out  XLEN  read data.
- busy1, busy2  out  1  scoreboard bit of A1 / A2.
- dbg_sel  in  AW  debug read address.
- dbg_data  out  XLEN  debug read data (never bypassed).

## Operation
- Register 0 reads as 0 on every port.
  - Writes to register 0 are ignored.
  - Its busy bit is never set.
- Extraction (writes only):
  - Byte: WD[8·addr+7 : 8·addr], extended to XLEN.
  - Half: WD[16·addr[1]+15 : 16·addr[1]]; addr[0] is ignored.
  - Word (00/11): WD passed through; lsign and addr are ignored.
- Clear engine FSM, states IDLE and INIT:
  - rst → INIT, ptr ← 1, all busy bits ← 0.
  - INIT: each cycle rf[ptr] ← 0 and ptr ← ptr+1. When ptr == NREG−1, go to IDLE.
  - IDLE with clr = 1 → INIT, ptr ← 1, all busy bits ← 0.
- While in INIT:
  - ready = 0.
  - we and set_busy are ignored.
  - RD1, RD2 and dbg_data return 0.
  - busy1 and busy2 return 0.
- Write (IDLE, we = 1, A3 ≠ 0): rf[A3] ← extracted value, busy[A3] ← 0.
- Scoreboard (IDLE, set_busy = 1, bsy_a ≠ 0): busy[bsy_a] ← 1.
- Same-cycle write and set_busy to the same register: data is written and the busy bit ends at 1 (set wins).
- Bypass (BYPASS = 1, IDLE, we = 1, A3 ≠ 0, A1 == A3): RD1 returns the extracted value. Same rule for RD2 with A2.
  - busy1 and busy2 are not bypassed; they reflect registered state.
- rst asserted in any state, including mid-INIT, restarts the sweep at ptr = 1.
- clr asserted in the same cycle as we: the write is performed, and INIT starts next cycle and then zeroes that register.

## Timing
- Reads are combinational from registered state plus the bypass mux; zero latency.
- Writes are visible on RD1/RD2 at the next cycle, or the same cycle through bypass.
- Reset edge E0 enters INIT. Edges E1…E(NREG−1) clear registers 1…NREG−1. ready rises after edge E(NREG−1): 31 cycles after the reset edge for NREG = 32.
- A clr sweep has the same duration as the reset sweep.
- Reset values:
  - ready = 0.
  - RD1, RD2, dbg_data = 0.
  - busy1, busy2 = 0.
  - State = INIT; all busy bits = 0.

## Structure
- Shared package rf_pkg holds:
  - mem_op encodings: MOP_WORD, MOP_BYTE, MOP_HALF, MOP_LOAD.
  - FSM state typedef: IDLE, INIT.
- Sub-module load_ext: combinational (WD, mem_op, lsign, addr) → extracted value. It feeds both the array write and the bypass mux.
- The $display register dumps of the previous register file are retained under an ifdef SIM guard.

## Test plan
- Reset sweep: preload registers, pulse rst for one cycle → ready = 0 for exactly 31 cycles (NREG = 32), then 1. All registers read 0. A write attempted mid-sweep is lost.
- Extraction: WD = 0x12F45678, addr = 2.
  - mem_op = 01, lsign = 1 → 0xFFFFFFF4.
  - mem_op = 01, lsign = 0 → 0x000000F4.
  - mem_op = 10, addr = 3, lsign = 1, WD = 0x80011234 → 0xFFFF8001.
- Bypass: write r5 = 0xDEADBEEF with A1 = 5 → RD1 = 0xDEADBEEF in the same cycle. With BYPASS = 0 → RD1 shows the old value, and the new value one cycle later.
- Scoreboard: set_busy r7 → busy1 = 1 next cycle (A1 = 7). Write r7 → busy1 = 0 next cycle. Write r7 and set_busy r7 together → busy1 stays 1 and the data is updated.
- r0: we = 1, A3 = 0, WD = 0xFFFFFFFF plus set_busy on 0 → RD1 = 0 and busy1 = 0 with A1 = 0.
- clr and rst: clr in IDLE → ready low for 31 cycles, busy bits cleared. rst asserted at sweep cycle 10 → sweep restarts, ready rises 31 cycles after the rst edge.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the extended register file: memory-op encodings
// and clear-engine states.
package rf_pkg;

    typedef enum logic [1:0] {
        MOP_WORD = 2'b00,
        MOP_BYTE = 2'b01,
        MOP_HALF = 2'b10,
        MOP_LOAD = 2'b11
    } mop_e;

    typedef enum logic {
        IDLE = 1'b0,
        INIT = 1'b1
    } rf_state_e;

endpackage

// File: rtl/load_ext.sv
// Load-result extraction: selects a byte or half-word by address offset and
// sign- or zero-extends it; word operations pass the data through.
module load_ext
    import rf_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] wd_i,
    input  logic [1:0]      mem_op_i,
    input  logic            lsign_i,
    input  logic [1:0]      addr_i,
    output logic [XLEN-1:0] ext_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = wd_i[{addr_i, 3'b000} +: 8];
        half_v = wd_i[{addr_i[1], 4'b0000} +: 16];
        case (mop_e'(mem_op_i))
            MOP_BYTE: ext_o = {{(XLEN-8){lsign_i & byte_v[7]}}, byte_v};
            MOP_HALF: ext_o = {{(XLEN-16){lsign_i & half_v[15]}}, half_v};
            default:  ext_o = wd_i;
        endcase
    end

endmodule

// File: rtl/regfile_ext.sv
// General-purpose register file with load extraction on writes, write-to-read
// bypass, a pending-load busy scoreboard and a sequential clear engine.
module regfile_ext
    import rf_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    localparam int unsigned AW    = $clog2(NREG),
    parameter bit          BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    output logic            ready,
    input  logic            we,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WD,
    input  logic [1:0]      mem_op,
    input  logic            lsign,
    input  logic [1:0]      addr,
    input  logic            set_busy,
    input  logic [AW-1:0]   bsy_a,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    output logic            busy1,
    output logic            busy2,
    input  logic [AW-1:0]   dbg_sel,
    output logic [XLEN-1:0] dbg_data
);

    rf_state_e       state_q;
    logic [AW-1:0]   ptr_q;
    logic [XLEN-1:0] rf_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [XLEN-1:0] ext_d;
    logic            wr_fire;
    logic            set_fire;

    load_ext #(.XLEN(XLEN)) u_ext (
        .wd_i     (WD),
        .mem_op_i (mem_op),
        .lsign_i  (lsign),
        .addr_i   (addr),
        .ext_o    (ext_d)
    );

    assign ready    = (state_q == IDLE);
    assign wr_fire  = ready & we & (A3 != '0);
    assign set_fire = ready & set_busy & (bsy_a != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            ptr_q   <= AW'(1);
            busy_q  <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    rf_q[ptr_q] <= '0;
                    ptr_q       <= ptr_q + AW'(1);
                    if (ptr_q == AW'(NREG - 1)) state_q <= IDLE;
                end
                default: begin
                    if (wr_fire) begin
                        rf_q[A3]   <= ext_d;
                        busy_q[A3] <= 1'b0;
                    end
                    // set after the write's clear so a same-cycle set wins
                    if (set_fire) busy_q[bsy_a] <= 1'b1;
                    if (clr) begin
                        state_q <= INIT;
                        ptr_q   <= AW'(1);
                        busy_q  <= '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        RD1      = '0;
        RD2      = '0;
        dbg_data = '0;
        if (ready && A1 != '0)
            RD1 = (BYPASS && wr_fire && A3 == A1) ? ext_d : rf_q[A1];
        if (ready && A2 != '0)
            RD2 = (BYPASS && wr_fire && A3 == A2) ? ext_d : rf_q[A2];
        if (ready && dbg_sel != '0)
            dbg_data = rf_q[dbg_sel];
    end

    assign busy1 = ready & busy_q[A1];
    assign busy2 = ready & busy_q[A2];

`ifdef SIM
    final begin
        for (int unsigned i = 0; i < NREG; i++)
            $display("r%0d = %h", i, rf_q[i]);
    end
`endif

endmodule

// File: tb/tb_regfile_ext.sv
// Directed, table-driven bench for regfile_ext with bypass and non-bypass copies.
module tb_regfile_ext;
    import rf_pkg::*;

    logic        clk = 1'b0;
    logic        rst, clr, we, lsign, set_busy;
    logic [4:0]  A1, A2, A3, bsy_a, dbg_sel;
    logic [31:0] WD;
    logic [1:0]  mem_op, addr;
    logic        ready, busy1, busy2;
    logic [31:0] RD1, RD2, dbg_data;
    logic        ready_nb, busy1_nb, busy2_nb;
    logic [31:0] RD1_nb, RD2_nb, dbg_nb;

    int passed = 0;
    int total  = 0;
    int n;

    always #5 clk = ~clk;

    regfile_ext #(.XLEN(32), .NREG(32), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .clr(clr), .ready(ready), .we(we),
        .A1(A1), .A2(A2), .A3(A3), .WD(WD), .mem_op(mem_op), .lsign(lsign),
        .addr(addr), .set_busy(set_busy), .bsy_a(bsy_a), .RD1(RD1), .RD2(RD2),
        .busy1(busy1), .busy2(busy2), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    regfile_ext #(.XLEN(32), .NREG(32), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .clr(clr), .ready(ready_nb), .we(we),
        .A1(A1), .A2(A2), .A3(A3), .WD(WD), .mem_op(mem_op), .lsign(lsign),
        .addr(addr), .set_busy(set_busy), .bsy_a(bsy_a), .RD1(RD1_nb), .RD2(RD2_nb),
        .busy1(busy1_nb), .busy2(busy2_nb), .dbg_sel(dbg_sel), .dbg_data(dbg_nb)
    );

    typedef struct {
        logic [1:0]  op;
        logic        sgn;
        logic [1:0]  ofs;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr = 0; we = 0; set_busy = 0; bsy_a = 0; A3 = 0; WD = 0;
        mem_op = 2'b00; lsign = 0; addr = 0;
    endtask

    // Counts edges until ready rises, bounded.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!ready && cnt < 200) begin
            tick();
            cnt++;
        end
    endtask

    task automatic write_reg(input logic [4:0] r, input logic [31:0] d);
        we = 1; A3 = r; WD = d; mem_op = 2'b00;
        tick();
        we = 0;
    endtask

    initial begin
        vecs[0] = '{2'b01, 1'b1, 2'd2, 32'h12F45678, 5'd1,  32'hFFFFFFF4};
        vecs[1] = '{2'b01, 1'b0, 2'd2, 32'h12F45678, 5'd2,  32'h000000F4};
        vecs[2] = '{2'b10, 1'b1, 2'd3, 32'h80011234, 5'd3,  32'hFFFF8001};
        vecs[3] = '{2'b10, 1'b0, 2'd0, 32'h80011234, 5'd4,  32'h00001234};
        vecs[4] = '{2'b01, 1'b1, 2'd3, 32'h12F45678, 5'd6,  32'h00000012};
        vecs[5] = '{2'b01, 1'b1, 2'd0, 32'h00000080, 5'd8,  32'hFFFFFF80};
        vecs[6] = '{2'b00, 1'b1, 2'd3, 32'hDEADBEEF, 5'd5,  32'hDEADBEEF};
        vecs[7] = '{2'b11, 1'b0, 2'd1, 32'h80000000, 5'd9,  32'h80000000};
        vecs[8] = '{2'b10, 1'b1, 2'd1, 32'h00007FFF, 5'd10, 32'h00007FFF};
        vecs[9] = '{2'b10, 1'b0, 2'd2, 32'hFFFF0000, 5'd11, 32'h0000FFFF};

        idle_inputs();
        A1 = 0; A2 = 0; dbg_sel = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
        chk("reset_ready", {31'b0, ready}, 32'd0);
        A1 = 3; A2 = 3; dbg_sel = 3; #1;
        chk("reset_rd1", RD1, 32'd0);
        chk("reset_busy1", {31'b0, busy1}, 32'd0);
        chk("reset_dbg", dbg_data, 32'd0);
        wait_ready(n);
        chk("init_sweep_len", n, 31);

        // Preload, then reset sweep with a write attempted mid-sweep.
        write_reg(5'd3, 32'hCAFE0003);
        write_reg(5'd31, 32'hCAFE001F);
        #1;
        chk("preload_r3", RD1, 32'hCAFE0003);
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("sweep_rd1_zero", RD1, 32'd0);
        n = 0;
        while (!ready && n < 200) begin
            if (n == 20) begin we = 1; A3 = 3; WD = 32'h0BAD0BAD; end
            else we = 0;
            tick();
            n++;
        end
        we = 0;
        chk("rst_sweep_len", n, 31);
        #1;
        chk("r3_cleared", RD1, 32'd0);
        dbg_sel = 31; #1;
        chk("r31_cleared", dbg_data, 32'd0);

        // Extraction table: bypass same cycle, stored value next cycle.
        foreach (vecs[i]) begin
            we = 1; A3 = vecs[i].rd; A1 = vecs[i].rd; A2 = vecs[i].rd;
            WD = vecs[i].wd; mem_op = vecs[i].op; lsign = vecs[i].sgn; addr = vecs[i].ofs;
            #1;
            chk($sformatf("byp_rd1_v%0d", i), RD1, vecs[i].exp);
            tick();
            we = 0; dbg_sel = vecs[i].rd; #1;
            chk($sformatf("stored_rd2_v%0d", i), RD2, vecs[i].exp);
            chk($sformatf("nb_rd1_v%0d", i), RD1_nb, vecs[i].exp);
            chk($sformatf("dbg_v%0d", i), dbg_data, vecs[i].exp);
        end
        idle_inputs();

        // Bypass vs. no bypass on r5 (currently 0xDEADBEEF).
        A1 = 5; we = 1; A3 = 5; WD = 32'h11111111; mem_op = 2'b00; dbg_sel = 5;
        #1;
        chk("bypass_rd1", RD1, 32'h11111111);
        chk("nobypass_rd1_old", RD1_nb, 32'hDEADBEEF);
        chk("dbg_not_bypassed", dbg_data, 32'hDEADBEEF);
        tick();
        we = 0; #1;
        chk("nobypass_rd1_new", RD1_nb, 32'h11111111);

        // Scoreboard on r7.
        A1 = 7; A2 = 7; set_busy = 1; bsy_a = 7;
        tick();
        set_busy = 0;
        chk("busy1_set", {31'b0, busy1}, 32'd1);
        chk("busy2_set", {31'b0, busy2}, 32'd1);
        we = 1; A3 = 7; WD = 32'h000000AA; #1;
        chk("busy_not_bypassed", {31'b0, busy1}, 32'd1);
        tick();
        we = 0; #1;
        chk("busy1_cleared", {31'b0, busy1}, 32'd0);
        we = 1; A3 = 7; WD = 32'h000000BB; set_busy = 1; bsy_a = 7;
        tick();
        we = 0; set_busy = 0; #1;
        chk("set_wins_busy", {31'b0, busy1}, 32'd1);
        chk("set_wins_data", RD1, 32'h000000BB);

        // Register 0.
        A1 = 0; we = 1; A3 = 0; WD = 32'hFFFFFFFF; set_busy = 1; bsy_a = 0; #1;
        chk("r0_bypass", RD1, 32'd0);
        tick();
        we = 0; set_busy = 0; #1;
        chk("r0_rd1", RD1, 32'd0);
        chk("r0_busy1", {31'b0, busy1}, 32'd0);

        // clr sweep with a same-cycle write to r12.
        A1 = 7; clr = 1; we = 1; A3 = 12; WD = 32'h55555555;
        tick();
        clr = 0; we = 0;
        chk("clr_ready_low", {31'b0, ready}, 32'd0);
        wait_ready(n);
        chk("clr_sweep_len", n, 31);
        #1;
        chk("clr_busy1", {31'b0, busy1}, 32'd0);
        chk("clr_r7", RD1, 32'd0);
        dbg_sel = 12; #1;
        chk("clr_r12", dbg_data, 32'd0);

        // rst at sweep cycle 10 restarts the sweep.
        write_reg(5'd7, 32'h77777777);
        clr = 1;
        tick();
        clr = 0;
        for (int k = 0; k < 9; k++) tick();
        rst = 1;
        tick();
        rst = 0;
        wait_ready(n);
        chk("rst_mid_sweep_len", n, 31);
        #1;
        chk("rst_mid_r7", RD1, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
